ace_snoop_responder: RTL and testbench

- Cache-master (GPGPU L1/L2) side responder for the ACE snoop channels.
- Accepts AC snoop requests from the interconnect and looks up the local cache tag/state array.
- Returns a CR response and, when required, streams the full line on CD, then commits the resulting line-state change.
- One snoop is in flight at a time; the block sits between the cache controller and the ACE port.

---
 rtl/ace_snoop_responder_pkg.sv | 69 ++++++
 rtl/ace_snoop_responder_decode.sv | 71 +++++++
 rtl/ace_snoop_responder.sv | 156 +++++++++++++++
 tb/tb_ace_snoop_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_snoop_responder_pkg.sv
// Shared widths, snoop-type codes, CR response bit positions and FSM states
// for the ACE snoop responder.
`ifndef ACE_SNOOP_WIDTH
`define ACE_SNOOP_WIDTH 4
`endif
`ifndef ACE_ADDR_WIDTH
`define ACE_ADDR_WIDTH 32
`endif
`ifndef ACE_PROT_WIDTH
`define ACE_PROT_WIDTH 3
`endif
`ifndef ACE_CRRESP_WIDTH
`define ACE_CRRESP_WIDTH 5
`endif
`ifndef ACE_DATA_WIDTH
`define ACE_DATA_WIDTH 64
`endif

package ace_snoop_responder_pkg;

  localparam int SNOOP_W  = `ACE_SNOOP_WIDTH;
  localparam int ADDR_W   = `ACE_ADDR_WIDTH;
  localparam int PROT_W   = `ACE_PROT_WIDTH;
  localparam int CRRESP_W = `ACE_CRRESP_WIDTH;
  localparam int DATA_W   = `ACE_DATA_WIDTH;

  localparam logic [SNOOP_W-1:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [SNOOP_W-1:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [SNOOP_W-1:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [SNOOP_W-1:0] SNP_READ_NSD      = 4'b0011;
  localparam logic [SNOOP_W-1:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [SNOOP_W-1:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [SNOOP_W-1:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [SNOOP_W-1:0] SNP_MAKE_INVALID  = 4'b1101;

  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;

  typedef struct packed {
    logic dt;
    logic err;
    logic pass_dirty;
    logic is_shared;
    logic was_unique;
  } snp_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP,
    ST_RD,
    ST_RDW,
    ST_CD,
    ST_UPD
  } snp_state_t;

  function automatic logic snp_supported(input logic [SNOOP_W-1:0] s);
    case (s)
      SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD,
      SNP_READ_UNIQUE, SNP_CLEAN_SHARED, SNP_CLEAN_INVALID,
      SNP_MAKE_INVALID: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ace_snoop_responder_decode.sv
// Combinational map from snoop type and local line state to the CR response
// and the line-state update to commit afterwards.
module ace_snoop_decode
  import ace_snoop_responder_pkg::*;
(
  input  logic [SNOOP_W-1:0] i_snoop,
  input  logic               i_hit,
  input  logic               i_dirty,
  input  logic               i_unique,
  output snp_resp_t          o_resp,
  output logic               o_inval,
  output logic               o_clr_dirty,
  output logic               o_clr_unique
);

  always_comb begin
    o_resp       = '0;
    o_inval      = 1'b0;
    o_clr_dirty  = 1'b0;
    o_clr_unique = 1'b0;
    // A miss (or unsupported type, which never looks up) answers all-zero.
    if (i_hit) begin
      case (i_snoop)
        SNP_READ_ONCE: begin
          o_resp.dt         = 1'b1;
          o_resp.is_shared  = 1'b1;
          o_resp.was_unique = i_unique;
        end
        SNP_READ_SHARED, SNP_READ_NSD: begin
          o_resp.dt         = 1'b1;
          o_resp.pass_dirty = i_dirty;
          o_resp.is_shared  = 1'b1;
          o_resp.was_unique = i_unique;
          o_clr_dirty       = i_dirty;
          o_clr_unique      = i_unique;
        end
        SNP_READ_CLEAN: begin
          o_resp.dt         = 1'b1;
          o_resp.is_shared  = 1'b1;
          o_resp.was_unique = i_unique;
          o_clr_unique      = i_unique;
        end
        SNP_READ_UNIQUE: begin
          o_resp.dt         = 1'b1;
          o_resp.pass_dirty = i_dirty;
          o_resp.was_unique = i_unique;
          o_inval           = 1'b1;
        end
        SNP_CLEAN_INVALID: begin
          o_resp.dt         = i_dirty;
          o_resp.pass_dirty = i_dirty;
          o_resp.was_unique = i_unique;
          o_inval           = 1'b1;
        end
        SNP_CLEAN_SHARED: begin
          o_resp.dt         = i_dirty;
          o_resp.pass_dirty = i_dirty;
          o_resp.is_shared  = 1'b1;
          o_resp.was_unique = i_unique;
          o_clr_dirty       = i_dirty;
        end
        SNP_MAKE_INVALID: begin
          o_resp.was_unique = i_unique;
          o_inval           = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks up the local
// cache, answers on CR, streams the line on CD when required, then commits.
//   state     | meaning
//   ST_IDLE   | waiting for an AC snoop
//   ST_LOOKUP | tag lookup outstanding
//   ST_RESP   | CR response offered
//   ST_RD     | data-array read issued for r_beat
//   ST_RDW    | read data returning, captured into cddata
//   ST_CD     | CD beat offered
//   ST_UPD    | line-state update pulse
module ace_snoop_responder
  import ace_snoop_responder_pkg::*;
#(
  parameter int LINE_BYTES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acvalid,
  output logic                acready,
  input  logic [SNOOP_W-1:0]  acsnoop,
  input  logic [ADDR_W-1:0]   acaddr,
  input  logic [PROT_W-1:0]   acprot,
  output logic                crvalid,
  input  logic                crready,
  output logic [CRRESP_W-1:0] crresp,
  output logic                cdvalid,
  input  logic                cdready,
  output logic [DATA_W-1:0]   cddata,
  output logic                cdlast,
  output logic                lk_req,
  output logic [ADDR_W-1:0]   lk_addr,
  input  logic                lk_ack,
  input  logic                lk_hit,
  input  logic                lk_dirty,
  input  logic                lk_unique,
  output logic                rd_req,
  output logic [((LINE_BYTES/(DATA_W/8)) > 1 ? $clog2(LINE_BYTES/(DATA_W/8)) : 1)-1:0] rd_beat,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                upd_req,
  output logic                upd_inval,
  output logic                upd_clr_dirty,
  output logic                upd_clr_unique,
  output logic                snp_busy
);

  localparam int BEATS  = LINE_BYTES / (DATA_W / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS_W  = $clog2(LINE_BYTES);

  snp_state_t          r_state, w_next;
  logic                r_acready;
  logic [SNOOP_W-1:0]  r_snoop;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_hit, r_dirty, r_unique;
  logic [BEAT_W-1:0]   r_beat;
  logic [DATA_W-1:0]   r_cddata;

  snp_resp_t           w_resp;
  logic                w_inval, w_clr_dirty, w_clr_unique, w_upd_any;
  logic                w_accept, w_last;
  logic                w_unused_prot;

  assign w_unused_prot = ^acprot;

  ace_snoop_decode u_decode (
    .i_snoop      (r_snoop),
    .i_hit        (r_hit),
    .i_dirty      (r_dirty),
    .i_unique     (r_unique),
    .o_resp       (w_resp),
    .o_inval      (w_inval),
    .o_clr_dirty  (w_clr_dirty),
    .o_clr_unique (w_clr_unique)
  );

  assign w_upd_any = w_inval | w_clr_dirty | w_clr_unique;
  assign w_accept  = acvalid & r_acready & (r_state == ST_IDLE);
  assign w_last    = (r_beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = snp_supported(acsnoop) ? ST_LOOKUP : ST_RESP;
      ST_LOOKUP: if (lk_ack) w_next = ST_RESP;
      ST_RESP:   if (crready) w_next = w_resp.dt ? ST_RD : (w_upd_any ? ST_UPD : ST_IDLE);
      ST_RD:     w_next = ST_RDW;
      ST_RDW:    w_next = ST_CD;
      ST_CD:     if (cdready) w_next = !w_last ? ST_RD : (w_upd_any ? ST_UPD : ST_IDLE);
      ST_UPD:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    acready        = r_acready;
    lk_req         = (r_state == ST_LOOKUP);
    lk_addr        = r_addr;
    crvalid        = (r_state == ST_RESP);
    crresp         = '0;
    cdvalid        = (r_state == ST_CD);
    cddata         = r_cddata;
    cdlast         = (r_state == ST_CD) && w_last;
    rd_req         = (r_state == ST_RD);
    rd_beat        = r_beat;
    upd_req        = (r_state == ST_UPD);
    upd_inval      = (r_state == ST_UPD) && w_inval;
    upd_clr_dirty  = (r_state == ST_UPD) && w_clr_dirty;
    upd_clr_unique = (r_state == ST_UPD) && w_clr_unique;
    snp_busy       = (r_state != ST_IDLE);
    if (r_state == ST_RESP) begin
      crresp[CR_DT]  = w_resp.dt;
      crresp[CR_ERR] = w_resp.err;
      crresp[CR_PD]  = w_resp.pass_dirty;
      crresp[CR_IS]  = w_resp.is_shared;
      crresp[CR_WU]  = w_resp.was_unique;
    end
  end

  // acready is registered off the current state, so it comes back one cycle
  // after IDLE is re-entered and drops the cycle after an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acready <= 1'b0;
      r_snoop   <= '0;
      r_addr    <= '0;
      r_hit     <= 1'b0;
      r_dirty   <= 1'b0;
      r_unique  <= 1'b0;
      r_beat    <= '0;
      r_cddata  <= '0;
    end else begin
      r_acready <= (r_state == ST_IDLE) && !w_accept;
      if (w_accept) begin
        r_snoop  <= acsnoop;
        r_addr   <= {acaddr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        r_hit    <= 1'b0;
        r_dirty  <= 1'b0;
        r_unique <= 1'b0;
        r_beat   <= '0;
      end
      if (r_state == ST_LOOKUP && lk_ack) begin
        r_hit    <= lk_hit;
        r_dirty  <= lk_dirty;
        r_unique <= lk_unique;
      end
      if (r_state == ST_RDW) r_cddata <= rd_data;
      if (r_state == ST_CD && cdready && !w_last) r_beat <= r_beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: hand-written vector table,
// multi-cycle corner sequences, and randomized snoops against a rule model.
module tb_ace_snoop_responder;
  import ace_snoop_responder_pkg::*;

  localparam int NBEATS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                acvalid = 1'b0, acready;
  logic [SNOOP_W-1:0]  acsnoop = '0;
  logic [ADDR_W-1:0]   acaddr = '0;
  logic [PROT_W-1:0]   acprot = '0;
  logic                crvalid, crready = 1'b0;
  logic [CRRESP_W-1:0] crresp;
  logic                cdvalid, cdready = 1'b0, cdlast;
  logic [DATA_W-1:0]   cddata;
  logic                lk_req, lk_ack;
  logic [ADDR_W-1:0]   lk_addr;
  logic                lk_hit = 1'b0, lk_dirty = 1'b0, lk_unique = 1'b0;
  logic                rd_req;
  logic [2:0]          rd_beat;
  logic [DATA_W-1:0]   rd_data;
  logic                upd_req, upd_inval, upd_clr_dirty, upd_clr_unique, snp_busy;

  ace_snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .acvalid(acvalid), .acready(acready), .acsnoop(acsnoop), .acaddr(acaddr), .acprot(acprot),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack),
    .lk_hit(lk_hit), .lk_dirty(lk_dirty), .lk_unique(lk_unique),
    .rd_req(rd_req), .rd_beat(rd_beat), .rd_data(rd_data),
    .upd_req(upd_req), .upd_inval(upd_inval), .upd_clr_dirty(upd_clr_dirty),
    .upd_clr_unique(upd_clr_unique), .snp_busy(snp_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: actual %0h required %0h", tag, name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] a, input logic [2:0] b);
    return {a, 24'hC0FFEE, 5'b0, b};
  endfunction

  // Cache model: lookup acks after m_lat cycles; data array returns 1 cycle after rd_req.
  int lk_cnt;
  int m_lat = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_ack <= 1'b0;
      lk_cnt <= 0;
    end else begin
      lk_ack <= 1'b0;
      if (lk_req && !lk_ack) begin
        if (lk_cnt >= m_lat) begin lk_ack <= 1'b1; lk_cnt <= 0; end
        else lk_cnt <= lk_cnt + 1;
      end
    end
  end

  always @(posedge clk)
    rd_data <= rd_req ? beat_data(lk_addr, rd_beat) : 64'hDEADBEEF0BADF00D;

  typedef struct packed {
    logic [4:0] resp;   // {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    logic       inval;
    logic       cd;
    logic       cu;
  } exp_t;

  typedef struct packed {
    logic [3:0] s;
    logic       h, d, u;
    exp_t       e;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] s, input logic h, d, u,
                               input logic [4:0] resp, input logic inval, cd, cu);
    vec_t v;
    v.s = s; v.h = h; v.d = d; v.u = u;
    v.e.resp = resp; v.e.inval = inval; v.e.cd = cd; v.e.cu = cu;
    return v;
  endfunction

  function automatic bit is_supported(input logic [3:0] s);
    logic [3:0] ok [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h8, 4'h9, 4'hD};
    foreach (ok[i]) if (ok[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  // Reference rules: response bits and line-state change per snoop type.
  function automatic exp_t model(input logic [3:0] s, input logic h, d, u);
    exp_t e;
    logic dt, pd, is;
    e = '0;
    if (!h || !is_supported(s)) return e;
    dt = 0; pd = 0; is = 0;
    case (s)
      4'h0: begin dt = 1; is = 1; end
      4'h1, 4'h3: begin dt = 1; pd = d; is = 1; e.cd = d; e.cu = u; end
      4'h2: begin dt = 1; is = 1; e.cu = u; end
      4'h7: begin dt = 1; pd = d; e.inval = 1; end
      4'h9: begin dt = d; pd = d; e.inval = 1; end
      4'h8: begin dt = d; pd = d; is = 1; e.cd = d; end
      4'hD: begin e.inval = 1; end
      default: ;
    endcase
    e.resp = {u, is, pd, 1'b0, dt};
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    chk(tag, "ctrl_outs_zero",
        {45'b0, acready, crvalid, crresp, cdvalid, cdlast, lk_req, rd_req, rd_beat,
         upd_req, upd_inval, upd_clr_dirty, upd_clr_unique, snp_busy}, 64'h0);
    chk(tag, "cddata_zero", cddata, 64'h0);
    chk(tag, "lk_addr_zero", {32'b0, lk_addr}, 64'h0);
  endtask

  task automatic run_snoop(input string tag, input logic [3:0] s, input logic [31:0] addr,
                           input logic h, d, u, input exp_t e, input int lat,
                           input int stall_beat, input int stall_len, input int abort_beat,
                           input bit rnd);
    logic [31:0] al;
    logic [4:0]  cr_first;
    logic [2:0]  uflags;
    int beats, rdreqs, upds, cyc, stall_left, exp_beats;
    bit saw_lk, lk_bad, overlap, cr_seen, cr_done, cr_unstable, cd_early, aborted;
    al = {addr[31:6], 6'b0};
    beats = 0; rdreqs = 0; upds = 0; stall_left = stall_len;
    saw_lk = 0; lk_bad = 0; overlap = 0; cr_seen = 0; cr_done = 0;
    cr_unstable = 0; cd_early = 0; aborted = 0; cr_first = '0; uflags = '0;
    exp_beats = e.resp[0] ? NBEATS : 0;
    lk_hit = h; lk_dirty = d; lk_unique = u; m_lat = lat;

    cyc = 0;
    while (!acready && cyc < 20) begin @(negedge clk); cyc++; end
    chk(tag, "acready_wait", acready, 1);
    acvalid = 1; acsnoop = s; acaddr = addr; acprot = PROT_W'($urandom);
    @(negedge clk);
    acvalid = 0; acsnoop = SNOOP_W'($urandom); acaddr = $urandom;

    cyc = 0;
    while (snp_busy && cyc < 400) begin
      if (lk_req) begin saw_lk = 1; if (lk_addr !== al) lk_bad = 1; end
      if (crvalid && cdvalid) overlap = 1;
      if (cdvalid && !cr_done) cd_early = 1;
      if (rd_req) rdreqs++;
      if (upd_req) begin upds++; uflags = {upd_inval, upd_clr_dirty, upd_clr_unique}; end
      crready = 0; cdready = 0;
      if (crvalid) begin
        if (!cr_seen) begin cr_seen = 1; cr_first = crresp; end
        else if (crresp !== cr_first) cr_unstable = 1;
        crready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (crready) cr_done = 1;
      end
      if (cdvalid) begin
        chk(tag, $sformatf("cddata_beat%0d", beats), cddata, beat_data(al, 3'(beats)));
        chk(tag, $sformatf("cdlast_beat%0d", beats), cdlast, (beats == NBEATS - 1));
        if (beats == abort_beat) begin
          rst_n = 0; crready = 0; cdready = 0;
          #1;
          check_all_zero({tag, "_abort"});
          repeat (3) begin
            @(negedge clk);
            if (upd_req) upds++;
          end
          rst_n = 1;
          #1;
          chk(tag, "acready_low_after_release", acready, 0);
          @(negedge clk);
          chk(tag, "acready_rises", acready, 1);
          aborted = 1;
          break;
        end
        if (beats == stall_beat && stall_left > 0) stall_left--;
        else begin
          cdready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (cdready) beats++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    crready = 0; cdready = 0;
    chk(tag, "no_timeout", (cyc < 400), 1);
    chk(tag, "lookup_issued", saw_lk, is_supported(s));
    chk(tag, "lk_addr_aligned", lk_bad, 0);
    chk(tag, "cr_cd_overlap", overlap, 0);
    chk(tag, "cd_before_cr", cd_early, 0);
    chk(tag, "crresp", cr_first, e.resp);
    chk(tag, "crresp_stable", cr_unstable, 0);
    if (aborted) begin
      chk(tag, "beats_before_abort", beats, abort_beat);
      chk(tag, "rd_req_before_abort", rdreqs, abort_beat + 1);
      chk(tag, "no_upd_after_abort", upds, 0);
    end else begin
      chk(tag, "cd_beats", beats, exp_beats);
      chk(tag, "rd_req_count", rdreqs, exp_beats);
      chk(tag, "upd_count", upds, (e.inval | e.cd | e.cu) ? 1 : 0);
      chk(tag, "upd_flags", uflags, {e.inval, e.cd, e.cu});
      chk(tag, "acready_gap", acready, 0);
    end
  endtask

  vec_t vt[13];

  initial begin
    exp_t e;
    logic [3:0] s;
    logic h, d, u;

    vt[0]  = mkv(4'b0001, 1, 1, 1, 5'b11101, 0, 1, 1);
    vt[1]  = mkv(4'b1101, 1, 0, 0, 5'b00000, 1, 0, 0);
    vt[2]  = mkv(4'b1000, 1, 0, 0, 5'b01000, 0, 0, 0);
    vt[3]  = mkv(4'b0000, 1, 1, 1, 5'b11001, 0, 0, 0);
    vt[4]  = mkv(4'b0011, 1, 1, 0, 5'b01101, 0, 1, 0);
    vt[5]  = mkv(4'b0010, 1, 1, 1, 5'b11001, 0, 0, 1);
    vt[6]  = mkv(4'b0111, 1, 1, 0, 5'b00101, 1, 0, 0);
    vt[7]  = mkv(4'b1001, 1, 1, 1, 5'b10101, 1, 0, 0);
    vt[8]  = mkv(4'b1001, 1, 0, 1, 5'b10000, 1, 0, 0);
    vt[9]  = mkv(4'b1000, 1, 1, 0, 5'b01101, 0, 1, 0);
    vt[10] = mkv(4'b0111, 0, 1, 1, 5'b00000, 0, 0, 0);
    vt[11] = mkv(4'b0000, 1, 0, 0, 5'b01001, 0, 0, 0);
    vt[12] = mkv(4'b1101, 1, 0, 1, 5'b10000, 1, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset", "acready_low_at_release", acready, 0);
    @(negedge clk);
    chk("reset", "acready_one_cycle_after", acready, 1);

    foreach (vt[i])
      run_snoop($sformatf("vec%0d", i), vt[i].s, 32'h1000_0040 + 32'(i) * 32'h40,
                vt[i].h, vt[i].d, vt[i].u, vt[i].e, i % 3, -1, 0, -1, 0);

    run_snoop("unaligned_miss", 4'b0111, 32'h1000_0047, 0, 0, 0, '0, 1, -1, 0, -1, 0);
    run_snoop("stall_beat3", 4'b0001, 32'h2000_0080, 1, 1, 1,
              mkv(4'b0001, 1, 1, 1, 5'b11101, 0, 1, 1).e, 0, 3, 5, -1, 0);
    run_snoop("reset_beat4", 4'b0001, 32'h3000_00C0, 1, 1, 1,
              mkv(4'b0001, 1, 1, 1, 5'b11101, 0, 1, 1).e, 0, -1, 0, 4, 0);
    run_snoop("unsupported_1111", 4'b1111, 32'h3000_0100, 1, 1, 1, '0, 0, -1, 0, -1, 0);

    for (int n = 0; n < 60; n++) begin
      s = 4'($urandom_range(0, 15));
      h = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      e = model(s, h, d, u);
      run_snoop($sformatf("rand%0d_s%0h", n, s), s, $urandom, h, d, u, e,
                $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3), -1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
